// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the multiplexed-input scan controller.
package mux_scan_pkg;

    localparam int NCH            = 4;
    localparam int SEL_W          = 2;
    localparam int SETTLE_CYC_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DWELL,
        S_REPORT
    } state_e;

endpackage

// File: rtl/rr_next_ch.sv
// Round-robin search for the next enabled channel strictly above current,
// wrapping; falls back to current itself when it is the only one enabled.
module rr_next_ch
    import mux_scan_pkg::*;
(
    input  logic [SEL_W-1:0] current,
    input  logic [NCH-1:0]   mask,
    output logic [SEL_W-1:0] next,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        next = current;
        idx  = current;
        any  = |mask;
        for (int i = NCH; i >= 1; i--) begin
            idx = SEL_W'((int'(current) + i) % NCH);
            if (mask[idx]) next = idx;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans enabled mux channels: settle after each sel change, count y_in high
// cycles over a dwell window, then hold the result until the consumer takes it.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DWELL_W    = 8,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [NCH-1:0]     mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               y_in,
    output logic [SEL_W-1:0]   sel,
    output logic               meas_valid,
    input  logic               meas_ready,
    output logic [SEL_W-1:0]   meas_ch,
    output logic [DWELL_W-1:0] meas_hi,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] hi_q, hi_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [SEL_W-1:0]   rr_cur, rr_nxt;
    logic               rr_any;
    logic [DWELL_W-1:0] dwell_lat;

    // From IDLE, searching above the top channel yields the lowest enabled one.
    assign rr_cur    = (state_q == S_IDLE) ? SEL_W'(NCH - 1) : sel_q;
    assign dwell_lat = (dwell == '0) ? DWELL_W'(1) : dwell;

    rr_next_ch u_rr (
        .current (rr_cur),
        .mask    (mask),
        .next    (rr_nxt),
        .any     (rr_any)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        dwell_d = dwell_q;
        unique case (state_q)
            S_IDLE: begin
                if (start && rr_any) begin
                    state_d = S_SETTLE;
                    sel_d   = rr_nxt;
                    dwell_d = dwell_lat;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == DWELL_W'(SETTLE_CYC - 1)) begin
                    state_d = S_DWELL;
                    cnt_d   = '0;
                    hi_d    = '0;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_DWELL: begin
                hi_d = hi_q + DWELL_W'(y_in);
                if (cnt_q == dwell_q - DWELL_W'(1)) begin
                    state_d = S_REPORT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DWELL_W'(1);
                end
            end
            S_REPORT: begin
                if (meas_ready) begin
                    if (rr_any) begin
                        state_d = S_SETTLE;
                        sel_d   = rr_nxt;
                        dwell_d = dwell_lat;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hi_d    = '0;
        end
        valid_d = (state_d == S_REPORT);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            dwell_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign meas_ch    = sel_q;
    assign meas_hi    = hi_q;
    assign meas_valid = valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: expected (channel, count) pairs are queued
// at stimulus time and popped whenever a result is handed over.
module tb_mux_scan_ctrl;
    import mux_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, stop = 1'b0, y_in = 1'b0, meas_ready = 1'b1;
    logic [3:0] mask = 4'h0;
    logic [7:0] dwell = 8'd0;
    logic [1:0] sel, meas_ch;
    logic [7:0] meas_hi;
    logic       meas_valid, busy;

    typedef struct {
        int ch;
        int hi;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0, n_xfer = 0;
    int   cyc = 0, last_x = -1, exp_per = 0;
    bit   per_en = 0, tog_en = 0;

    mux_scan_ctrl #(.NCH(4), .DWELL_W(8), .SETTLE_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mask       (mask),
        .dwell      (dwell),
        .y_in       (y_in),
        .sel        (sel),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .meas_ch    (meas_ch),
        .meas_hi    (meas_hi),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (tog_en) #1 y_in = ~y_in;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Handover monitor: sampled mid-cycle, a valid&ready here is taken on the next edge.
    always @(negedge clk) begin
        if (rst_n && meas_valid && meas_ready) begin
            if (sb.size() == 0) begin
                chk("unexp_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("meas_ch", int'(meas_ch), e.ch);
                chk("meas_hi", int'(meas_hi), e.hi);
            end
            if (per_en && last_x >= 0) chk("period", cyc - last_x, exp_per);
            last_x = cyc;
            n_xfer++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int ch, input int hi);
        exp_t e;
        e.ch = ch;
        e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic abort();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("busy_after_stop", int'(busy), 0);
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) tick(1);
        chk("drain_left", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        // reset state, applied between clock edges
        #1 rst_n = 1'b0;
        #2;
        chk("rst_sel", int'(sel), 0);
        chk("rst_valid", int'(meas_valid), 0);
        chk("rst_ch", int'(meas_ch), 0);
        chk("rst_hi", int'(meas_hi), 0);
        chk("rst_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        chk("idle_after_rst", int'(busy), 0);

        // full scan, back-to-back handovers
        mask = 4'hF; dwell = 8'd8; y_in = 1'b1; meas_ready = 1'b1;
        push(0, 8); push(1, 8); push(2, 8); push(3, 8); push(0, 8);
        per_en = 1; exp_per = 11; last_x = -1;
        pulse_start();
        chk("busy_start", int'(busy), 1);
        chk("sel_first", int'(sel), 0);
        drain(100);
        per_en = 0;
        abort();

        // sparse mask with a toggling input
        mask = 4'b0101; dwell = 8'd10; y_in = 1'b0; tog_en = 1;
        push(0, 5); push(2, 5); push(0, 5);
        pulse_start();
        drain(100);
        tog_en = 0;
        abort();

        // backpressure
        mask = 4'b0010; dwell = 8'd3; y_in = 1'b1; meas_ready = 1'b0;
        push(1, 3);
        pulse_start();
        for (int i = 0; i < 30 && !meas_valid; i++) tick(1);
        chk("bp_valid_rise", int'(meas_valid), 1);
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("bp_valid", int'(meas_valid), 1);
            chk("bp_ch", int'(meas_ch), 1);
            chk("bp_hi", int'(meas_hi), 3);
            chk("bp_sel", int'(sel), 1);
        end
        x0 = n_xfer;
        meas_ready = 1'b1;
        tick(1);
        chk("bp_valid_drop", int'(meas_valid), 0);
        tick(3);
        chk("bp_one_xfer", n_xfer - x0, 1);
        chk("bp_sb_empty", sb.size(), 0);
        abort();

        // abort in the fourth dwell cycle, then resume
        mask = 4'b0110; dwell = 8'd10; y_in = 1'b1;
        pulse_start();
        tick(5);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_valid", int'(meas_valid), 0);
        chk("abort_hi", int'(meas_hi), 0);
        x0 = n_xfer;
        tick(20);
        chk("abort_no_xfer", n_xfer - x0, 0);
        push(1, 10);
        pulse_start();
        chk("resume_sel", int'(sel), 1);
        drain(60);
        abort();

        // start with empty mask
        mask = 4'h0;
        start = 1'b1;
        tick(3);
        start = 1'b0;
        chk("empty_mask_busy", int'(busy), 0);

        // zero dwell behaves as a one-cycle window
        mask = 4'b1000; dwell = 8'd0; y_in = 1'b1;
        push(3, 1);
        pulse_start();
        drain(30);
        abort();

        // mask cleared mid-window: result still reported, then idle
        mask = 4'hF; dwell = 8'd5; y_in = 1'b1;
        push(0, 5);
        pulse_start();
        tick(4);
        mask = 4'h0;
        drain(30);
        tick(1);
        chk("mask_clr_idle", int'(busy), 0);
        chk("mask_clr_valid", int'(meas_valid), 0);

        // asynchronous reset mid-window
        mask = 4'hF; dwell = 8'd20; y_in = 1'b1;
        pulse_start();
        tick(6);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sel", int'(sel), 0);
        chk("arst_valid", int'(meas_valid), 0);
        chk("arst_ch", int'(meas_ch), 0);
        chk("arst_hi", int'(meas_hi), 0);
        chk("arst_busy", int'(busy), 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        chk("arst_stay_idle", int'(busy), 0);
        chk("final_sb", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: NCH, 4, number of mux data channels; fixed at 4 for this revision.
REQ-002 Parameter: DWELL_W, 8, width of the dwell length and high-count fields.
REQ-003 Parameter: SETTLE_CYC, 2, number of cycles between a sel change and the first sample (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; begins scanning when sampled high in IDLE.
REQ-007 stop  in  1  level; aborts scanning from any state.
REQ-008 mask  in  4  channel enable mask; bit i enables channel i.
REQ-009 dwell  in  DWELL_W  measurement window length in cycles.
REQ-010 y_in  in  1  shared 4:1 mux output being measured.
REQ-011 sel  out  2  select driven to the 4:1 mux.
REQ-012 meas_valid  out  1  result available.
REQ-013 meas_ready  in  1  consumer accepts the result.
REQ-014 meas_ch  out  2  channel that the result belongs to.
REQ-015 meas_hi  out  DWELL_W  count of cycles with y_in high in the window.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE, DWELL and REPORT.
- IDLE->SETTLE: start=1, stop=0 and mask!=0.
- SETTLE->DWELL: after SETTLE_CYC cycles.
- DWELL->REPORT: after the window has completed.
- REPORT->SETTLE: meas_ready=1 and mask!=0.
- REPORT->IDLE: meas_ready=1 and mask==0.
REQ-018 start with mask==0 SHALL leave the block in IDLE with busy=0; start while busy=1 SHALL be ignored.
REQ-019 On leaving IDLE, sel SHALL be set to the lowest enabled channel.
REQ-020 On leaving REPORT, sel SHALL be set to the next enabled channel above the current one (round-robin, wrapping 3->0).
- If only the current channel is enabled, sel SHALL remain unchanged.
REQ-021 dwell SHALL be latched on entry to SETTLE; dwell==0 SHALL be treated as 1; later changes SHALL apply from the next window.
REQ-022 In DWELL, the counter SHALL increment once per cycle in which y_in=1.
- The window SHALL be exactly the latched dwell number of cycles.
- meas_hi SHALL never exceed the latched dwell value.
REQ-023 In REPORT:
- meas_valid SHALL be 1.
- meas_ch, meas_hi and sel SHALL remain stable until the cycle in which meas_ready=1.
- meas_valid SHALL deassert in the cycle after acceptance.
REQ-024 A mask change during SETTLE or DWELL SHALL NOT abort the current window; the next channel SHALL be chosen from mask as sampled at acceptance.
REQ-025 stop=1 in any state SHALL force IDLE on the next edge, discard any partial window or result, and drive meas_valid=0; stop SHALL win over a simultaneous start.
REQ-026 With meas_ready held high, consecutive meas_valid pulses SHALL be SETTLE_CYC+dwell+1 cycles apart.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately force: state=IDLE, sel=0, meas_valid=0, meas_ch=0, meas_hi=0, busy=0, and all counters to 0.
- This SHALL hold regardless of clk, including mid-window.
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Structure
REQ-029 Package mux_scan_pkg SHALL hold the state enum type, NCH, SEL_W=2, and the default SETTLE_CYC.
REQ-030 The round-robin next-enabled-channel search SHALL be a combinational sub-module named rr_next_ch (inputs: current, mask; outputs: next, any).

Verification
REQ-031 Full scan: mask=1111, dwell=8, y_in=1, ready=1 -> meas_ch sequence 0,1,2,3,0 with meas_hi=8 each, pulses 11 cycles apart.
REQ-032 Sparse mask, toggling input: mask=0101, dwell=10, y_in toggling every cycle -> meas_ch sequence 0,2,0 with meas_hi=5 each.
REQ-033 Backpressure: meas_ready=0 for 20 cycles in REPORT -> meas_valid, meas_ch, meas_hi and sel all stable; exactly one transfer on release.
REQ-034 Abort: stop pulsed at cycle 4 of DWELL -> busy=0 next cycle, no meas_valid; a later start resumes at the lowest enabled channel.
REQ-035 Edge cases:
- mask=0000 with start -> stays IDLE.
- dwell=0 with y_in=1 -> meas_hi=1.
- mask cleared during DWELL -> result reported, then IDLE.
REQ-036 Asynchronous reset: rst_n pulsed low mid-DWELL, between clock edges -> all outputs at reset values before the next edge.
